// File: rtl/ifs_deser_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifs_pkg : shared types and sizing helpers for ifs_deser_bank       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ifs_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      RUN  = 1'b1
   } ifs_state_t;

   localparam int MAX_RATIO  = 8;
   localparam int MAX_STAGES = 4;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifs_deser_bank_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifs_capture_stage : clock-enabled pad capture chain with init value|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ifs_capture_stage #(
   parameter int               WIDTH    = 8,
   parameter int               STAGES   = 1,
   parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             sclr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) r_stage[i] <= INIT_VAL;
      end else if (sclr) begin
         for (int i = 0; i < STAGES; i++) r_stage[i] <= INIT_VAL;
      end else if (ce) begin
         r_stage[0] <= d;
         for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ifs_deser_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifs_deser_bank : WIDTH-lane capture + 1:RATIO deserialiser w/ SLIP |
// | Optional QPAR word parity when IFS_DESER_PARITY_EN is defined.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ifs_deser_bank
   import ifs_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               RATIO    = 4,
   parameter int               STAGES   = 1,
   parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
   input  logic                   SCLK,
   input  logic                   RSTN,
   input  logic [WIDTH-1:0]       D,
   input  logic                   CE,
   input  logic                   SCLR,
   input  logic                   SLIP,
   output logic [WIDTH*RATIO-1:0] Q,
   output logic                   QVALID
`ifdef IFS_DESER_PARITY_EN
   ,
   output logic                   QPAR
`endif
);

   localparam int CW = cnt_width(MAX_RATIO);
   localparam int FW = cnt_width(MAX_STAGES);
   localparam logic [CW-1:0] C_CNT_LAST  = CW'(RATIO - 1);
   localparam logic [FW-1:0] C_FILL_LAST = FW'(STAGES - 1);

   logic [WIDTH-1:0]       w_last;
   logic [WIDTH*RATIO-1:0] w_word;
   logic [WIDTH*RATIO-1:0] r_asm;
   logic [CW-1:0]          r_cnt;
   logic [FW-1:0]          r_fill;
   ifs_state_t             r_state;

   ifs_capture_stage #(
      .WIDTH    (WIDTH),
      .STAGES   (STAGES),
      .INIT_VAL (INIT_VAL)
   ) u_cap (
      .clk   (SCLK),
      .rst_n (RSTN),
      .ce    (CE),
      .sclr  (SCLR),
      .d     (D),
      .q     (w_last)
   );

   // The word being built with the current last-stage sample dropped into slot cnt.
   always_comb begin
      w_word = r_asm;
      w_word[r_cnt*WIDTH +: WIDTH] = w_last;
   end

   always_ff @(posedge SCLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= FILL;
         r_fill  <= '0;
         r_cnt   <= '0;
         r_asm   <= '0;
         Q       <= '0;
         QVALID  <= 1'b0;
`ifdef IFS_DESER_PARITY_EN
         QPAR    <= 1'b0;
`endif
      end else if (SCLR) begin
         r_state <= FILL;
         r_fill  <= '0;
         r_cnt   <= '0;
         r_asm   <= '0;
         Q       <= '0;
         QVALID  <= 1'b0;
`ifdef IFS_DESER_PARITY_EN
         QPAR    <= 1'b0;
`endif
      end else begin
         QVALID <= 1'b0;
         if (CE) begin
            case (r_state)
               FILL: begin
                  // Stay here until the chain holds only real samples.
                  if (r_fill == C_FILL_LAST) r_state <= RUN;
                  else                       r_fill  <= r_fill + 1'b1;
               end
               RUN: begin
                  if (!SLIP) begin
                     r_asm <= w_word;
                     if (r_cnt == C_CNT_LAST) begin
                        r_cnt  <= '0;
                        Q      <= w_word;
                        QVALID <= 1'b1;
`ifdef IFS_DESER_PARITY_EN
                        QPAR   <= ^w_word;
`endif
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= FILL;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifs_deser_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ifs_deser_bank : scoreboard bench, three configurations         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ifs_deser_bank;

   typedef struct {
      bit          word;
      logic [31:0] data;
      int          at;
   } ev_t;

   logic       sclk = 1'b0;
   logic       rstn = 1'b1;
   logic [7:0] d    = '0;
   logic       ce   = 1'b0;
   logic       sclr = 1'b0;
   logic       slip = 1'b0;

   logic [31:0] q0, q2;
   logic [7:0]  q1;
   logic        qv0, qv1, qv2;
`ifdef IFS_DESER_PARITY_EN
   logic        qp0, qp1, qp2;
`endif

   int cyc  = 0;
   int nchk = 0;
   int nerr = 0;
   bit done = 1'b0;

   logic [7:0]  hist [3][$];
   logic [7:0]  part [3][$];
   ev_t         sb   [3][$];
   logic [31:0] hold [3];

   always #5 sclk = ~sclk;
   always @(posedge sclk) cyc <= cyc + 1;

   ifs_deser_bank #(.WIDTH(8), .RATIO(4), .STAGES(1), .INIT_VAL(8'h00)) u0 (
      .SCLK(sclk), .RSTN(rstn), .D(d), .CE(ce), .SCLR(sclr), .SLIP(slip),
      .Q(q0), .QVALID(qv0)
`ifdef IFS_DESER_PARITY_EN
      , .QPAR(qp0)
`endif
   );
   ifs_deser_bank #(.WIDTH(8), .RATIO(1), .STAGES(1), .INIT_VAL(8'h00)) u1 (
      .SCLK(sclk), .RSTN(rstn), .D(d), .CE(ce), .SCLR(sclr), .SLIP(slip),
      .Q(q1), .QVALID(qv1)
`ifdef IFS_DESER_PARITY_EN
      , .QPAR(qp1)
`endif
   );
   ifs_deser_bank #(.WIDTH(8), .RATIO(4), .STAGES(3), .INIT_VAL(8'hA5)) u2 (
      .SCLK(sclk), .RSTN(rstn), .D(d), .CE(ce), .SCLR(sclr), .SLIP(slip),
      .Q(q2), .QVALID(qv2)
`ifdef IFS_DESER_PARITY_EN
      , .QPAR(qp2)
`endif
   );

   function automatic int rat(input int k);
      return (k == 1) ? 1 : 4;
   endfunction
   function automatic int stg(input int k);
      return (k == 2) ? 3 : 1;
   endfunction
   function automatic logic [7:0] ival(input int k);
      return (k == 2) ? 8'hA5 : 8'h00;
   endfunction
   function automatic logic [31:0] qsel(input int k);
      return (k == 0) ? q0 : (k == 1) ? 32'(q1) : q2;
   endfunction
   function automatic logic qvsel(input int k);
      return (k == 0) ? qv0 : (k == 1) ? qv1 : qv2;
   endfunction
   function automatic logic [7:0] lastsel(input int k);
      return (k == 0) ? u0.w_last : (k == 1) ? u1.w_last : u2.w_last;
   endfunction
`ifdef IFS_DESER_PARITY_EN
   function automatic logic qpsel(input int k);
      return (k == 0) ? qp0 : (k == 1) ? qp1 : qp2;
   endfunction
`endif

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[u%0d] cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
      end
   endtask

   // Reference: a sample leaves the chain STAGES accepted edges after entering;
   // non-slipped leavers are collected oldest-first into RATIO-sample words.
   task automatic step(input int k);
      logic [7:0]  s;
      logic [31:0] w;
      ev_t         e;
      if (!rstn || sclr) begin
         hist[k].delete();
         part[k].delete();
         if (rstn) begin
            e.word = 1'b0; e.data = '0; e.at = cyc + 1;
            sb[k].push_back(e);
         end
      end else if (ce) begin
         if (hist[k].size() == stg(k)) begin
            s = hist[k].pop_front();
            if (!slip) begin
               part[k].push_back(s);
               if (part[k].size() == rat(k)) begin
                  w = '0;
                  for (int j = 0; j < rat(k); j++) w[j*8 +: 8] = part[k][j];
                  part[k].delete();
                  e.word = 1'b1; e.data = w; e.at = cyc + 1;
                  sb[k].push_back(e);
               end
            end
         end
         hist[k].push_back(d);
      end
   endtask

   task automatic mon(input int k);
      ev_t e;
      if (!rstn) begin
         sb[k].delete();
         hold[k] = '0;
         check("reset_q", k, qsel(k), 32'd0);
         check("reset_qvalid", k, 32'(qvsel(k)), 32'd0);
         check("reset_stage", k, 32'(lastsel(k)), 32'(ival(k)));
      end else if (sb[k].size() != 0 && sb[k][0].at == cyc) begin
         e = sb[k].pop_front();
         check(e.word ? "word_qvalid" : "sclr_qvalid", k, 32'(qvsel(k)), 32'(e.word));
         check(e.word ? "word_q" : "sclr_q", k, qsel(k), e.data);
         hold[k] = e.data;
      end else begin
         check("idle_qvalid", k, 32'(qvsel(k)), 32'd0);
         check("hold_q", k, qsel(k), hold[k]);
      end
`ifdef IFS_DESER_PARITY_EN
      check("qpar", k, 32'(qpsel(k)), 32'(^hold[k]));
`endif
   endtask

   task automatic drive(input logic [7:0] dv, input logic cev, input logic slv, input logic clr);
      @(posedge sclk);
      #1;
      d = dv; ce = cev; slip = slv; sclr = clr;
      for (int k = 0; k < 3; k++) step(k);
   endtask

   task automatic async_reset();
      @(posedge sclk);
      #3;
      rstn = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      rstn = 1'b1;
   endtask

   // Monitor: all comparisons happen here, away from the rising edge.
   initial begin
      forever begin
         @(negedge sclk or negedge rstn);
         #1;
         if (done) begin
            for (int k = 0; k < 3; k++) check("pending_words", k, 32'(sb[k].size()), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
            $finish;
         end
         for (int k = 0; k < 3; k++) mon(k);
      end
   end

   initial begin
      #2 rstn = 1'b0;
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);
      rstn = 1'b1;

      // Basic word 0x44332211
      for (int i = 1; i <= 5; i++) drive(8'(8'h11 * i), 1'b1, 1'b0, 1'b0);
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // Same data with CE gaps
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         drive(8'(8'h11 * i), 1'b1, 1'b0, 1'b0);
         drive(8'hEE, 1'b0, 1'b0, 1'b0);
      end
      repeat (2) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // SLIP on the edges that would push 0x02 and 0x04
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 12; i++) drive(8'(i), 1'b1, (i == 3 || i == 5), 1'b0);
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // SCLR two samples into a word, then a clean word
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) drive(8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
      drive(8'h00, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) drive(8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
      repeat (2) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // Odd-parity word 0x44332210
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      drive(8'h10, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i <= 5; i++) drive(8'(8'h11 * i), 1'b1, 1'b0, 1'b0);
      repeat (2) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // Async reset mid-word
      for (int i = 1; i <= 3; i++) drive(8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
      async_reset();

      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 149) async_reset();
         else drive(8'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
      end
      repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b0);
      done = 1'b1;
      repeat (20) @(posedge sclk);
      $display("FAIL monitor did not terminate");
      $fatal(1);
   end

endmodule
`default_nettype wire
